// File: rtl/switch_arbiter.sv
// Two-input, two-output packet scheduler. Routes each packet to output A or B by address
// and arbitrates round-robin, per output, when both held packets target the same side.
module switch_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_SPLIT = 64,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in0_vld,
  output logic                  in0_rdy,
  input  logic [ADDR_WIDTH-1:0] in0_addr,
  input  logic [DATA_WIDTH-1:0] in0_data,
  input  logic                  in1_vld,
  output logic                  in1_rdy,
  input  logic [ADDR_WIDTH-1:0] in1_addr,
  input  logic [DATA_WIDTH-1:0] in1_data,
  output logic                  vld_a,
  output logic [ADDR_WIDTH-1:0] addr_a,
  output logic [DATA_WIDTH-1:0] data_a,
  output logic                  vld_b,
  output logic [ADDR_WIDTH-1:0] addr_b,
  output logic [DATA_WIDTH-1:0] data_b,
  output logic [CNT_WIDTH-1:0]  conflict_cnt
);

  localparam logic [ADDR_WIDTH:0] SPLIT = ADDR_SPLIT[ADDR_WIDTH:0];

  logic                  h0_vld_q, h1_vld_q;
  logic [ADDR_WIDTH-1:0] h0_addr_q, h1_addr_q;
  logic [DATA_WIDTH-1:0] h0_data_q, h1_data_q;
  logic                  h0_dest_q, h1_dest_q;
  logic                  rr_a_q, rr_b_q;

  logic                  in0_dest, in1_dest;
  logic                  same, rr_sel, grant0, grant1;
  logic                  sel0_a, sel1_a, sel0_b, sel1_b;
  logic [CNT_WIDTH-1:0]  cnt_d;

  always_comb begin
    in0_dest = ({1'b0, in0_addr} >= SPLIT);
    in1_dest = ({1'b0, in1_addr} >= SPLIT);
    same     = h0_vld_q & h1_vld_q & (h0_dest_q == h1_dest_q);
    rr_sel   = h0_dest_q ? rr_b_q : rr_a_q;
    grant0   = h0_vld_q & (~same | ~rr_sel);
    grant1   = h1_vld_q & (~same | rr_sel);
    in0_rdy  = ~h0_vld_q | grant0;
    in1_rdy  = ~h1_vld_q | grant1;
    sel0_a   = grant0 & ~h0_dest_q;
    sel1_a   = grant1 & ~h1_dest_q;
    sel0_b   = grant0 & h0_dest_q;
    sel1_b   = grant1 & h1_dest_q;
    cnt_d    = conflict_cnt;
    if (same && (conflict_cnt != '1)) cnt_d = conflict_cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h0_vld_q     <= 1'b0;
      h0_addr_q    <= '0;
      h0_data_q    <= '0;
      h0_dest_q    <= 1'b0;
      h1_vld_q     <= 1'b0;
      h1_addr_q    <= '0;
      h1_data_q    <= '0;
      h1_dest_q    <= 1'b0;
      rr_a_q       <= 1'b0;
      rr_b_q       <= 1'b0;
      vld_a        <= 1'b0;
      addr_a       <= '0;
      data_a       <= '0;
      vld_b        <= 1'b0;
      addr_b       <= '0;
      data_b       <= '0;
      conflict_cnt <= '0;
    end else begin
      if (in0_rdy) begin
        h0_vld_q  <= in0_vld;
        h0_addr_q <= in0_addr;
        h0_data_q <= in0_data;
        h0_dest_q <= in0_dest;
      end
      if (in1_rdy) begin
        h1_vld_q  <= in1_vld;
        h1_addr_q <= in1_addr;
        h1_data_q <= in1_data;
        h1_dest_q <= in1_dest;
      end
      // Pointer moves to the loser: in1 lost exactly when in0 was granted.
      if (same && !h0_dest_q) rr_a_q <= grant0;
      if (same &&  h0_dest_q) rr_b_q <= grant0;

      vld_a <= sel0_a | sel1_a;
      if (sel0_a) begin
        addr_a <= h0_addr_q;
        data_a <= h0_data_q;
      end else if (sel1_a) begin
        addr_a <= h1_addr_q;
        data_a <= h1_data_q;
      end
      vld_b <= sel0_b | sel1_b;
      if (sel0_b) begin
        addr_b <= h0_addr_q;
        data_b <= h0_data_q;
      end else if (sel1_b) begin
        addr_b <= h1_addr_q;
        data_b <= h1_data_q;
      end
      conflict_cnt <= cnt_d;
    end
  end

endmodule

// File: tb/tb_switch_arbiter.sv
// Bench for switch_arbiter: directed scenarios plus random traffic, every cycle compared
// against a behavioural model of holds, per-output round-robin and the conflict counter.
module tb_switch_arbiter;

  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in0_vld = 1'b0, in1_vld = 1'b0;
  logic        in0_rdy, in1_rdy;
  logic [7:0]  in0_addr = '0, in1_addr = '0;
  logic [15:0] in0_data = '0, in1_data = '0;
  logic        vld_a, vld_b;
  logic [7:0]  addr_a, addr_b;
  logic [15:0] data_a, data_b;
  logic [CW-1:0] conflict_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  switch_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .ADDR_SPLIT(64), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .in0_vld(in0_vld), .in0_rdy(in0_rdy), .in0_addr(in0_addr), .in0_data(in0_data),
    .in1_vld(in1_vld), .in1_rdy(in1_rdy), .in1_addr(in1_addr), .in1_data(in1_data),
    .vld_a(vld_a), .addr_a(addr_a), .data_a(data_a),
    .vld_b(vld_b), .addr_b(addr_b), .data_b(data_b),
    .conflict_cnt(conflict_cnt)
  );

  // Model state: index 0/1 = input for holds, index 0/1 = output A/B for outputs and pointers.
  bit          m_v[2];
  logic [7:0]  m_a[2];
  logic [15:0] m_d[2];
  int          m_rr[2];
  bit          m_ov[2];
  logic [7:0]  m_oa[2];
  logic [15:0] m_od[2];
  int          m_cnt;
  logic [15:0] seen_a[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic int side(input logic [7:0] a);
    return (int'(a) >= 64) ? 1 : 0;
  endfunction

  function automatic logic [1:0] m_grants();
    logic [1:0] g = '0;
    for (int o = 0; o < 2; o++) begin
      int n = 0;
      int who = 0;
      for (int i = 0; i < 2; i++)
        if (m_v[i] && side(m_a[i]) == o) begin n++; who = i; end
      if (n == 1) g[who] = 1'b1;
      else if (n == 2) g[m_rr[o]] = 1'b1;
    end
    return g;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 2; i++) begin
      m_v[i] = 0; m_a[i] = '0; m_d[i] = '0; m_rr[i] = 0;
      m_ov[i] = 0; m_oa[i] = '0; m_od[i] = '0;
    end
    m_cnt = 0;
  endtask

  task automatic m_clock(input bit iv[2], input logic [7:0] ia[2], input logic [15:0] id[2]);
    logic [1:0] g = m_grants();
    for (int o = 0; o < 2; o++) begin
      if (m_v[0] && m_v[1] && side(m_a[0]) == o && side(m_a[1]) == o) begin
        if (m_cnt < CMAX) m_cnt++;
        m_rr[o] = 1 - m_rr[o];
      end
      m_ov[o] = 0;
      for (int i = 0; i < 2; i++)
        if (g[i] && side(m_a[i]) == o) begin
          m_ov[o] = 1; m_oa[o] = m_a[i]; m_od[o] = m_d[i];
        end
    end
    for (int i = 0; i < 2; i++)
      if (!m_v[i] || g[i]) begin
        m_v[i] = iv[i]; m_a[i] = ia[i]; m_d[i] = id[i];
      end
  endtask

  // Drive one cycle of input (called at a negedge), compare DUT with model, advance both.
  task automatic step(input bit v0, input logic [7:0] a0, input logic [15:0] d0,
                      input bit v1, input logic [7:0] a1, input logic [15:0] d1,
                      output bit acc0, output bit acc1);
    bit          iv[2];
    logic [7:0]  ia[2];
    logic [15:0] id[2];
    logic [1:0]  g;
    in0_vld = v0; in0_addr = a0; in0_data = d0;
    in1_vld = v1; in1_addr = a1; in1_data = d1;
    #1;
    g = m_grants();
    check("in0_rdy", 32'(in0_rdy), 32'(!m_v[0] || g[0]));
    check("in1_rdy", 32'(in1_rdy), 32'(!m_v[1] || g[1]));
    check("vld_a",   32'(vld_a),  32'(m_ov[0]));
    check("addr_a",  32'(addr_a), 32'(m_oa[0]));
    check("data_a",  32'(data_a), 32'(m_od[0]));
    check("vld_b",   32'(vld_b),  32'(m_ov[1]));
    check("addr_b",  32'(addr_b), 32'(m_oa[1]));
    check("data_b",  32'(data_b), 32'(m_od[1]));
    check("conflict_cnt", 32'(conflict_cnt), 32'(m_cnt));
    if (vld_a) seen_a.push_back(data_a);
    acc0 = v0 && (!m_v[0] || g[0]);
    acc1 = v1 && (!m_v[1] || g[1]);
    iv[0] = v0; ia[0] = a0; id[0] = d0;
    iv[1] = v1; ia[1] = a1; id[1] = d1;
    @(posedge clk);
    m_clock(iv, ia, id);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bit x0, x1;
    for (int k = 0; k < n; k++) step(0, '0, '0, 0, '0, '0, x0, x1);
  endtask

  // Both inputs stream continuously; payload advances only after a handshake.
  task automatic stream(input int n, input logic [7:0] a, input logic [15:0] b0, input logic [15:0] b1);
    logic [15:0] d0 = b0, d1 = b1;
    bit acc0, acc1;
    for (int k = 0; k < n; k++) begin
      step(1, a, d0, 1, a, d1, acc0, acc1);
      if (acc0) d0++;
      if (acc1) d1++;
    end
  endtask

  // Assert reset away from any edge; outputs must clear immediately.
  task automatic mid_reset();
    #2 rst = 1'b1;
    #1;
    m_reset();
    check("rst_vld_a", 32'(vld_a), 0);
    check("rst_vld_b", 32'(vld_b), 0);
    check("rst_addr_a", 32'(addr_a), 0);
    check("rst_data_b", 32'(data_b), 0);
    check("rst_cnt", 32'(conflict_cnt), 0);
    check("rst_rdy0", 32'(in0_rdy), 1);
    check("rst_rdy1", 32'(in1_rdy), 1);
    in0_vld = 1'b0; in1_vld = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    bit x0, x1;
    m_reset();
    @(negedge clk);
    rst = 1'b0;
    idle(2);

    // Stream some traffic first so the mid-cycle reset has state to clear.
    step(1, 8'h22, 16'h7777, 1, 8'h90, 16'h8888, x0, x1);
    mid_reset();

    // Single packet to A.
    step(1, 8'h10, 16'h1234, 0, '0, '0, x0, x1);
    step(0, '0, '0, 0, '0, '0, x0, x1);
    check("single_vld_a", 32'(vld_a), 1);
    check("single_addr_a", 32'(addr_a), 32'h10);
    check("single_data_a", 32'(data_a), 32'h1234);
    check("single_vld_b", 32'(vld_b), 0);
    idle(1);

    // Parallel, different outputs.
    step(1, 8'h05, 16'hAAAA, 1, 8'h80, 16'h5555, x0, x1);
    step(0, '0, '0, 0, '0, '0, x0, x1);
    check("par_data_a", 32'(data_a), 32'hAAAA);
    check("par_data_b", 32'(data_b), 32'h5555);
    check("par_vld", 32'({vld_a, vld_b}), 32'b11);
    check("par_cnt", 32'(conflict_cnt), 0);
    idle(1);

    // Address boundaries.
    step(1, 8'h3F, 16'h0101, 1, 8'h40, 16'h0202, x0, x1);
    step(1, 8'hFF, 16'h0303, 1, 8'h00, 16'h0404, x0, x1);
    check("bnd_3F_a", 32'({vld_a, addr_a}), 32'h13F);
    check("bnd_40_b", 32'({vld_b, addr_b}), 32'h140);
    step(0, '0, '0, 0, '0, '0, x0, x1);
    check("bnd_00_a", 32'({vld_a, addr_a}), 32'h100);
    check("bnd_FF_b", 32'({vld_b, addr_b}), 32'h1FF);
    idle(1);

    // Contention: alternating winners starting with in0.
    seen_a.delete();
    stream(6, 8'h20, 16'h0001, 16'h1001);
    check("cont_n", 32'(seen_a.size()), 4);
    if (seen_a.size() == 4) begin
      check("cont_0", 32'(seen_a[0]), 32'h0001);
      check("cont_1", 32'(seen_a[1]), 32'h1001);
      check("cont_2", 32'(seen_a[2]), 32'h0002);
      check("cont_3", 32'(seen_a[3]), 32'h1002);
    end
    check("cont_cnt", 32'(conflict_cnt), 5);

    // Reset with packets still held: they must never appear, and rr restarts at in0.
    mid_reset();
    seen_a.delete();
    idle(3);
    check("drop_none", 32'(seen_a.size()), 0);
    stream(22, 8'h21, 16'h0A01, 16'h1A01);
    check("rr_restart", 32'(seen_a.size() > 0 ? seen_a[0] : 16'h0), 32'h0A01);
    check("cnt_sat", 32'(conflict_cnt), CMAX);
    idle(2);

    // Random traffic biased toward the split point and toward same-side collisions.
    for (int k = 0; k < 600; k++) begin
      bit v0 = ($urandom_range(3) != 0);
      bit v1 = ($urandom_range(3) != 0);
      logic [7:0] a0 = ($urandom_range(1) == 0) ? 8'($urandom_range(60, 68)) : 8'($urandom);
      logic [7:0] a1 = ($urandom_range(1) == 0) ? a0 : 8'($urandom);
      step(v0, a0, 16'($urandom), v1, a1, 16'($urandom), x0, x1);
      if (k == 300) mid_reset();
    end
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
